rename_map_table: RTL and testbench
===================================

# rename_map_table

Speculative register-rename stage between decode and dispatch. Each cycle it accepts up to DECODE_WIDTH decoded instructions and reads source mappings from the speculative RAT. It allocates destination physical registers from the free list, resolves intra-group dependencies, and registers the renamed group for dispatch. An architectural RAT, updated at commit, restores the speculative RAT on flush.

## Interface
- DECODE_WIDTH, 2, instructions renamed per cycle
- COMMIT_WIDTH, 2, commits per cycle
- ARCH_REG_NUM, 32, architectural registers; AW = clog2(ARCH_REG_NUM)
- PHY_REG_NUM, 64, physical registers, power of two; PW = clog2(PHY_REG_NUM)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush (mispredict/exception)
- dec_valid_i  in  DECODE_WIDTH  per-slot valid, contiguous from [0]
- dec_ready_o  out  1  group accepted when high
- dec_src0_i, dec_src1_i, dec_dst_i  in  DECODE_WIDTH×AW  arch registers
- dec_wen_i  in  DECODE_WIDTH  slot writes dst
- fl_alloc_valid_o  out  DECODE_WIDTH  compacted allocation request, contiguous from [0]
- fl_alloc_ready_i  in  1  free list has ≥DECODE_WIDTH entries
- fl_preg_i  in  DECODE_WIDTH×PW  allocated pregs, index = request rank
- ren_valid_o  out  DECODE_WIDTH  renamed slot valid (registered)
- ren_ready_i  in  1  dispatch accepts group
- ren_psrc0_o, ren_psrc1_o, ren_pdst_o, ren_old_pdst_o  out  DECODE_WIDTH×PW
- ren_wen_o  out  DECODE_WIDTH  registered effective write enable
- cmt_valid_i, cmt_wen_i  in  COMMIT_WIDTH  commit slots
- cmt_dst_i  in  COMMIT_WIDTH×AW; cmt_pdst_i  in  COMMIT_WIDTH×PW

## Operation
- Effective write: ew[i] = dec_valid_i[i] & dec_wen_i[i] & (dec_dst_i[i] != 0); r0 is never renamed and always maps to preg 0.
- stall = ren_valid_o != 0 & !ren_ready_i. dec_ready_o = fl_alloc_ready_i & !stall & !flush_i.
- fire = (dec_valid_i != 0) & dec_ready_o.
- fl_alloc_valid_o is popcount(ew) low bits set when fire, otherwise 0.
- Slot i takes fl_preg_i[rank(i)], where rank(i) = popcount(ew[i-1:0]).
- Sources: psrc of slot i = pdst of the highest j<i with ew[j] & dst[j]==src, else spec RAT[src]. src==0 always gives 0.
- ren_old_pdst_o uses the same rule with dst as the key. For slots with !ew it is 0 and ren_pdst_o is 0.
- Spec RAT write on fire: entry dst[i] <= pdst[i] for each ew slot; the highest slot wins on duplicate dst.
- Arch RAT write each cycle: entry cmt_dst_i[k] <= cmt_pdst_i[k] for cmt_valid & cmt_wen & dst != 0; the highest k wins.
- Flush: spec RAT <= next-state arch RAT, including same-cycle commits. ren_valid_o <= 0. No allocation occurs.
- Freeing old pdst to the free list is the ROB's job at commit, not this block's.

## Timing
- Reset: both RATs hold identity (arch i → preg i). ren_valid_o = 0. All ren_* fields = 0.
- Latency is 1 cycle. Decode inputs on a fire edge appear on ren_* after that edge.
- Output register loads on fire, holds on stall, and clears to 0 valid when !fire & !stall.
- The free list allocation and the spec RAT update happen on the same edge as the output load.
- Renamed groups read the spec RAT state before the same-cycle write; intra-group forwarding covers that gap.
- Flush has priority over fire and commit ordering. A commit in the flush cycle is visible in the restored spec RAT.
- When fl_alloc_ready_i = 0, no request is issued, dec_ready_o = 0, and the output drains normally.
- Reset asserted mid-operation returns to the reset state asynchronously.

## Structure
- Shared package: DECODE_WIDTH, COMMIT_WIDTH, ARCH_REG_NUM, PHY_REG_NUM, typedefs arch_reg_t and phy_reg_t, and the countones function.
- One sub-module, rename_dep_check: purely combinational intra-group comparison and forwarding, producing psrc/old_pdst select indices. The RAT arrays and output register stay in the top.

## Test plan
- Reset, then group {add r1←r2,r3; add r4←r1,r1}, fl_preg = {40,41} -> slot0 psrc 2/3, pdst 40, old 1. Slot1 psrc 40/40, pdst 41, old 4.
- Same dst twice (r5, r5), pregs {50,51} -> slot1 old_pdst 50. Next group reading r5 gets 51.
- dec_dst = 0 with wen = 1 -> no allocation (fl_alloc_valid_o = 0), pdst 0. Slot1 writing r6 uses fl_preg_i[0].
- ren_ready_i low for 3 cycles -> ren_* held stable, dec_ready_o = 0, no fl_alloc_valid_o, spec RAT unchanged.
- Rename r7→45, commit r7→30 earlier, flush with same-cycle commit r8→33 -> after flush, src r7 reads 30 and src r8 reads 33. ren_valid_o = 0.
- fl_alloc_ready_i = 0 with valid decode -> dec_ready_o = 0 until ready returns, then the group renames with correct pregs.

Source files
------------

// File: rtl/rename_map_table_pkg.sv
// Shared sizing, register-index types and helpers for the rename stage.
package rename_map_table_pkg;

    localparam int unsigned DECODE_WIDTH = 2;
    localparam int unsigned COMMIT_WIDTH = 2;
    localparam int unsigned ARCH_REG_NUM = 32;
    localparam int unsigned PHY_REG_NUM  = 64;

    localparam int unsigned AW = $clog2(ARCH_REG_NUM);
    localparam int unsigned PW = $clog2(PHY_REG_NUM);
    // Width of a slot index and of a per-group population count.
    localparam int unsigned SW = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;
    localparam int unsigned CW = $clog2(DECODE_WIDTH + 1);

    typedef logic [AW-1:0] arch_reg_t;
    typedef logic [PW-1:0] phy_reg_t;

    function automatic logic [CW-1:0] countones(input logic [DECODE_WIDTH-1:0] bits);
        logic [CW-1:0] total;
        total = '0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            total = total + CW'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/rename_map_table_dep_check.sv
// Intra-group dependency check: for each slot, finds the youngest older slot
// in the same group whose destination matches src0, src1 or dst.
module rename_dep_check
    import rename_map_table_pkg::*;
(
    input  logic [DECODE_WIDTH-1:0]    ew,
    input  logic [DECODE_WIDTH*AW-1:0] src0,
    input  logic [DECODE_WIDTH*AW-1:0] src1,
    input  logic [DECODE_WIDTH*AW-1:0] dst,
    output logic [DECODE_WIDTH-1:0]    src0_hit,
    output logic [DECODE_WIDTH-1:0]    src1_hit,
    output logic [DECODE_WIDTH-1:0]    dst_hit,
    output logic [DECODE_WIDTH*SW-1:0] src0_sel,
    output logic [DECODE_WIDTH*SW-1:0] src1_sel,
    output logic [DECODE_WIDTH*SW-1:0] dst_sel
);

    always_comb begin
        src0_hit = '0;
        src1_hit = '0;
        dst_hit  = '0;
        src0_sel = '0;
        src1_sel = '0;
        dst_sel  = '0;
        for (int unsigned i = 1; i < DECODE_WIDTH; i++) begin
            // Ascending scan so the highest matching older slot wins.
            for (int unsigned j = 0; j < i; j++) begin
                if (ew[j] && dst[j*AW +: AW] == src0[i*AW +: AW]) begin
                    src0_hit[i]          = 1'b1;
                    src0_sel[i*SW +: SW] = SW'(j);
                end
                if (ew[j] && dst[j*AW +: AW] == src1[i*AW +: AW]) begin
                    src1_hit[i]          = 1'b1;
                    src1_sel[i*SW +: SW] = SW'(j);
                end
                if (ew[j] && dst[j*AW +: AW] == dst[i*AW +: AW]) begin
                    dst_hit[i]          = 1'b1;
                    dst_sel[i*SW +: SW] = SW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rename_map_table.sv
// Speculative register rename: source lookup, destination allocation and
// registered renamed group; architectural RAT restores the speculative RAT on flush.
module rename_map_table
    import rename_map_table_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic [DECODE_WIDTH-1:0]     dec_valid_i,
    output logic                        dec_ready_o,
    input  logic [DECODE_WIDTH*AW-1:0]  dec_src0_i,
    input  logic [DECODE_WIDTH*AW-1:0]  dec_src1_i,
    input  logic [DECODE_WIDTH*AW-1:0]  dec_dst_i,
    input  logic [DECODE_WIDTH-1:0]     dec_wen_i,
    output logic [DECODE_WIDTH-1:0]     fl_alloc_valid_o,
    input  logic                        fl_alloc_ready_i,
    input  logic [DECODE_WIDTH*PW-1:0]  fl_preg_i,
    output logic [DECODE_WIDTH-1:0]     ren_valid_o,
    input  logic                        ren_ready_i,
    output logic [DECODE_WIDTH*PW-1:0]  ren_psrc0_o,
    output logic [DECODE_WIDTH*PW-1:0]  ren_psrc1_o,
    output logic [DECODE_WIDTH*PW-1:0]  ren_pdst_o,
    output logic [DECODE_WIDTH*PW-1:0]  ren_old_pdst_o,
    output logic [DECODE_WIDTH-1:0]     ren_wen_o,
    input  logic [COMMIT_WIDTH-1:0]     cmt_valid_i,
    input  logic [COMMIT_WIDTH-1:0]     cmt_wen_i,
    input  logic [COMMIT_WIDTH*AW-1:0]  cmt_dst_i,
    input  logic [COMMIT_WIDTH*PW-1:0]  cmt_pdst_i
);

    phy_reg_t spec_rat  [ARCH_REG_NUM];
    phy_reg_t arch_rat  [ARCH_REG_NUM];
    phy_reg_t arch_next [ARCH_REG_NUM];

    logic [DECODE_WIDTH-1:0]    ew;
    phy_reg_t                   pdst [DECODE_WIDTH];
    logic                       stall;
    logic                       fire;
    logic [CW-1:0]              alloc_cnt;
    logic [DECODE_WIDTH-1:0]    src0_hit, src1_hit, dst_hit;
    logic [DECODE_WIDTH*SW-1:0] src0_sel, src1_sel, dst_sel;
    logic [DECODE_WIDTH*PW-1:0] nxt_psrc0, nxt_psrc1, nxt_pdst, nxt_old;

    assign stall       = (ren_valid_o != '0) && !ren_ready_i;
    assign dec_ready_o = fl_alloc_ready_i && !stall && !flush_i;
    assign fire        = (dec_valid_i != '0) && dec_ready_o;

    // Writes to r0 are dropped so that r0 permanently maps to preg 0.
    always_comb begin
        int unsigned rank;
        rank = 0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            ew[i]   = dec_valid_i[i] && dec_wen_i[i] && (dec_dst_i[i*AW +: AW] != '0);
            pdst[i] = '0;
            if (ew[i]) begin
                pdst[i] = fl_preg_i[rank*PW +: PW];
                rank    = rank + 1;
            end
        end
    end

    always_comb begin
        alloc_cnt        = countones(ew);
        fl_alloc_valid_o = '0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            if (fire && CW'(i) < alloc_cnt) fl_alloc_valid_o[i] = 1'b1;
        end
    end

    rename_dep_check u_dep_check (
        .ew       (ew),
        .src0     (dec_src0_i),
        .src1     (dec_src1_i),
        .dst      (dec_dst_i),
        .src0_hit (src0_hit),
        .src1_hit (src1_hit),
        .dst_hit  (dst_hit),
        .src0_sel (src0_sel),
        .src1_sel (src1_sel),
        .dst_sel  (dst_sel)
    );

    always_comb begin
        arch_reg_t s0, s1, d;
        s0        = '0;
        s1        = '0;
        d         = '0;
        nxt_psrc0 = '0;
        nxt_psrc1 = '0;
        nxt_pdst  = '0;
        nxt_old   = '0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            s0 = dec_src0_i[i*AW +: AW];
            s1 = dec_src1_i[i*AW +: AW];
            d  = dec_dst_i[i*AW +: AW];
            if (dec_valid_i[i]) begin
                if (s0 != '0)
                    nxt_psrc0[i*PW +: PW] = src0_hit[i] ? pdst[src0_sel[i*SW +: SW]] : spec_rat[s0];
                if (s1 != '0)
                    nxt_psrc1[i*PW +: PW] = src1_hit[i] ? pdst[src1_sel[i*SW +: SW]] : spec_rat[s1];
                if (ew[i]) begin
                    nxt_pdst[i*PW +: PW] = pdst[i];
                    nxt_old[i*PW +: PW]  = dst_hit[i] ? pdst[dst_sel[i*SW +: SW]] : spec_rat[d];
                end
            end
        end
    end

    always_comb begin
        arch_next = arch_rat;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (cmt_valid_i[k] && cmt_wen_i[k] && cmt_dst_i[k*AW +: AW] != '0)
                arch_next[cmt_dst_i[k*AW +: AW]] = cmt_pdst_i[k*PW +: PW];
        end
    end

    // Flush restores from the post-commit arch state, so same-cycle commits survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ARCH_REG_NUM; i++) begin
                spec_rat[i] <= PW'(i);
                arch_rat[i] <= PW'(i);
            end
        end else begin
            arch_rat <= arch_next;
            if (flush_i) begin
                spec_rat <= arch_next;
            end else if (fire) begin
                for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
                    if (ew[i]) spec_rat[dec_dst_i[i*AW +: AW]] <= pdst[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_valid_o    <= '0;
            ren_wen_o      <= '0;
            ren_psrc0_o    <= '0;
            ren_psrc1_o    <= '0;
            ren_pdst_o     <= '0;
            ren_old_pdst_o <= '0;
        end else if (fire) begin
            ren_valid_o    <= dec_valid_i;
            ren_wen_o      <= ew;
            ren_psrc0_o    <= nxt_psrc0;
            ren_psrc1_o    <= nxt_psrc1;
            ren_pdst_o     <= nxt_pdst;
            ren_old_pdst_o <= nxt_old;
        end else if (flush_i || !stall) begin
            ren_valid_o    <= '0;
            ren_wen_o      <= '0;
            ren_psrc0_o    <= '0;
            ren_psrc1_o    <= '0;
            ren_pdst_o     <= '0;
            ren_old_pdst_o <= '0;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus a random
// run against a sequential rename model.
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       flush_i;
    logic [DECODE_WIDTH-1:0]    dec_valid_i, dec_wen_i;
    logic                       dec_ready_o;
    logic [DECODE_WIDTH*AW-1:0] dec_src0_i, dec_src1_i, dec_dst_i;
    logic [DECODE_WIDTH-1:0]    fl_alloc_valid_o;
    logic                       fl_alloc_ready_i;
    logic [DECODE_WIDTH*PW-1:0] fl_preg_i;
    logic [DECODE_WIDTH-1:0]    ren_valid_o, ren_wen_o;
    logic                       ren_ready_i;
    logic [DECODE_WIDTH*PW-1:0] ren_psrc0_o, ren_psrc1_o, ren_pdst_o, ren_old_pdst_o;
    logic [COMMIT_WIDTH-1:0]    cmt_valid_i, cmt_wen_i;
    logic [COMMIT_WIDTH*AW-1:0] cmt_dst_i;
    logic [COMMIT_WIDTH*PW-1:0] cmt_pdst_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rename_map_table dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .dec_valid_i      (dec_valid_i),
        .dec_ready_o      (dec_ready_o),
        .dec_src0_i       (dec_src0_i),
        .dec_src1_i       (dec_src1_i),
        .dec_dst_i        (dec_dst_i),
        .dec_wen_i        (dec_wen_i),
        .fl_alloc_valid_o (fl_alloc_valid_o),
        .fl_alloc_ready_i (fl_alloc_ready_i),
        .fl_preg_i        (fl_preg_i),
        .ren_valid_o      (ren_valid_o),
        .ren_ready_i      (ren_ready_i),
        .ren_psrc0_o      (ren_psrc0_o),
        .ren_psrc1_o      (ren_psrc1_o),
        .ren_pdst_o       (ren_pdst_o),
        .ren_old_pdst_o   (ren_old_pdst_o),
        .ren_wen_o        (ren_wen_o),
        .cmt_valid_i      (cmt_valid_i),
        .cmt_wen_i        (cmt_wen_i),
        .cmt_dst_i        (cmt_dst_i),
        .cmt_pdst_i       (cmt_pdst_i)
    );

    function automatic logic [PW-1:0] f_psrc0(input int i); return ren_psrc0_o[i*PW +: PW]; endfunction
    function automatic logic [PW-1:0] f_psrc1(input int i); return ren_psrc1_o[i*PW +: PW]; endfunction
    function automatic logic [PW-1:0] f_pdst(input int i);  return ren_pdst_o[i*PW +: PW];  endfunction
    function automatic logic [PW-1:0] f_old(input int i);   return ren_old_pdst_o[i*PW +: PW]; endfunction

    task automatic idle_inputs();
        flush_i          = 1'b0;
        dec_valid_i      = '0;
        dec_wen_i        = '0;
        dec_src0_i       = '0;
        dec_src1_i       = '0;
        dec_dst_i        = '0;
        fl_alloc_ready_i = 1'b1;
        fl_preg_i        = '0;
        ren_ready_i      = 1'b1;
        cmt_valid_i      = '0;
        cmt_wen_i        = '0;
        cmt_dst_i        = '0;
        cmt_pdst_i       = '0;
    endtask

    task automatic set_slot(input int i, input logic wen, input int dst, input int s0, input int s1);
        dec_valid_i[i]         = 1'b1;
        dec_wen_i[i]           = wen;
        dec_dst_i[i*AW +: AW]  = AW'(dst);
        dec_src0_i[i*AW +: AW] = AW'(s0);
        dec_src1_i[i*AW +: AW] = AW'(s1);
    endtask

    task automatic set_preg(input int p0, input int p1);
        fl_preg_i[0 +: PW]  = PW'(p0);
        fl_preg_i[PW +: PW] = PW'(p1);
    endtask

    task automatic set_commit(input int k, input int dst, input int pd);
        cmt_valid_i[k]         = 1'b1;
        cmt_wen_i[k]           = 1'b1;
        cmt_dst_i[k*AW +: AW]  = AW'(dst);
        cmt_pdst_i[k*PW +: PW] = PW'(pd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ren_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", ren_valid_o); end
        checks++; if (ren_pdst_o !== '0) begin errors++; $display("FAIL reset_pdst got %h want 0", ren_pdst_o); end
        checks++; if (ren_psrc0_o !== '0 || ren_psrc1_o !== '0 || ren_old_pdst_o !== '0 || ren_wen_o !== '0) begin
            errors++; $display("FAIL reset_fields got %h %h %h %b want 0", ren_psrc0_o, ren_psrc1_o, ren_old_pdst_o, ren_wen_o); end
        checks++; if (dec_ready_o !== 1'b1 || fl_alloc_valid_o !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b/%b want 1/00", dec_ready_o, fl_alloc_valid_o); end
        // Rename r3 -> 12, then assert reset between edges.
        set_slot(0, 1'b1, 3, 1, 2);
        set_preg(12, 13);
        step();
        checks++; if (ren_valid_o !== 2'b01) begin errors++; $display("FAIL pre_async_valid got %b want 01", ren_valid_o); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ren_valid_o !== 2'b00 || ren_pdst_o !== '0) begin
            errors++; $display("FAIL async_reset got valid %b pdst %h want 00/0", ren_valid_o, ren_pdst_o); end
        idle_inputs();
        #2 rst_n = 1'b1;
        step();
        set_slot(0, 1'b0, 0, 3, 0);
        step();
        checks++; if (f_psrc0(0) !== 6'd3 || ren_valid_o !== 2'b01) begin
            errors++; $display("FAIL async_identity got psrc %0d valid %b want 3/01", f_psrc0(0), ren_valid_o); end
        idle_inputs();
    endtask

    task automatic test_dependency();
        int exp_v[8] = '{2, 3, 40, 1, 40, 40, 41, 4};
        logic [PW-1:0] got[8];
        apply_reset();
        set_slot(0, 1'b1, 1, 2, 3);
        set_slot(1, 1'b1, 4, 1, 1);
        set_preg(40, 41);
        #1;
        checks++; if (fl_alloc_valid_o !== 2'b11 || dec_ready_o !== 1'b1) begin
            errors++; $display("FAIL dep_alloc got %b/%b want 11/1", fl_alloc_valid_o, dec_ready_o); end
        step();
        got = '{f_psrc0(0), f_psrc1(0), f_pdst(0), f_old(0), f_psrc0(1), f_psrc1(1), f_pdst(1), f_old(1)};
        for (int k = 0; k < 8; k++) begin
            checks++; if (got[k] !== PW'(exp_v[k])) begin errors++; $display("FAIL dep_field%0d got %0d want %0d", k, got[k], exp_v[k]); end
        end
        checks++; if (ren_valid_o !== 2'b11 || ren_wen_o !== 2'b11) begin
            errors++; $display("FAIL dep_valid got %b/%b want 11/11", ren_valid_o, ren_wen_o); end
        idle_inputs();
    endtask

    task automatic test_same_dst();
        apply_reset();
        set_slot(0, 1'b1, 5, 0, 0);
        set_slot(1, 1'b1, 5, 0, 0);
        set_preg(50, 51);
        step();
        checks++; if (f_old(0) !== 6'd5 || f_old(1) !== 6'd50) begin
            errors++; $display("FAIL samedst_old got %0d/%0d want 5/50", f_old(0), f_old(1)); end
        checks++; if (f_pdst(0) !== 6'd50 || f_pdst(1) !== 6'd51) begin
            errors++; $display("FAIL samedst_pdst got %0d/%0d want 50/51", f_pdst(0), f_pdst(1)); end
        idle_inputs();
        set_slot(0, 1'b0, 0, 5, 5);
        #1;
        checks++; if (fl_alloc_valid_o !== 2'b00) begin errors++; $display("FAIL samedst_noalloc got %b want 00", fl_alloc_valid_o); end
        @(posedge clk); #1;
        checks++; if (f_psrc0(0) !== 6'd51 || f_psrc1(0) !== 6'd51) begin
            errors++; $display("FAIL samedst_read got %0d/%0d want 51/51", f_psrc0(0), f_psrc1(0)); end
        idle_inputs();
    endtask

    task automatic test_r0_dst();
        apply_reset();
        set_slot(0, 1'b1, 0, 1, 2);
        #1;
        checks++; if (fl_alloc_valid_o !== 2'b00 || dec_ready_o !== 1'b1) begin
            errors++; $display("FAIL r0_alloc got %b/%b want 00/1", fl_alloc_valid_o, dec_ready_o); end
        @(posedge clk); #1;
        checks++; if (f_pdst(0) !== 6'd0 || f_old(0) !== 6'd0 || ren_wen_o !== 2'b00 || ren_valid_o !== 2'b01) begin
            errors++; $display("FAIL r0_out got pdst %0d old %0d wen %b valid %b want 0/0/00/01", f_pdst(0), f_old(0), ren_wen_o, ren_valid_o); end
        idle_inputs();
        set_slot(0, 1'b1, 0, 1, 2);
        set_slot(1, 1'b1, 6, 0, 0);
        set_preg(44, 55);
        #1;
        checks++; if (fl_alloc_valid_o !== 2'b01) begin errors++; $display("FAIL r0_rank_alloc got %b want 01", fl_alloc_valid_o); end
        @(posedge clk); #1;
        checks++; if (f_pdst(1) !== 6'd44 || f_old(1) !== 6'd6 || f_pdst(0) !== 6'd0 || ren_wen_o !== 2'b10) begin
            errors++; $display("FAIL r0_rank got pdst1 %0d old1 %0d pdst0 %0d wen %b want 44/6/0/10", f_pdst(1), f_old(1), f_pdst(0), ren_wen_o); end
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        set_slot(0, 1'b1, 9, 2, 0);
        set_preg(46, 47);
        step();
        ren_ready_i = 1'b0;
        dec_valid_i = '0;
        set_slot(0, 1'b1, 9, 9, 0);
        set_preg(60, 61);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (dec_ready_o !== 1'b0 || fl_alloc_valid_o !== 2'b00) begin
                errors++; $display("FAIL stall_ready c%0d got %b/%b want 0/00", c, dec_ready_o, fl_alloc_valid_o); end
            @(posedge clk); #1;
            checks++; if (ren_valid_o !== 2'b01 || f_pdst(0) !== 6'd46 || f_psrc0(0) !== 6'd2) begin
                errors++; $display("FAIL stall_hold c%0d got valid %b pdst %0d psrc %0d want 01/46/2", c, ren_valid_o, f_pdst(0), f_psrc0(0)); end
        end
        ren_ready_i = 1'b1;
        #1;
        checks++; if (dec_ready_o !== 1'b1 || fl_alloc_valid_o !== 2'b01) begin
            errors++; $display("FAIL stall_release got %b/%b want 1/01", dec_ready_o, fl_alloc_valid_o); end
        @(posedge clk); #1;
        checks++; if (f_psrc0(0) !== 6'd46 || f_pdst(0) !== 6'd60 || f_old(0) !== 6'd46) begin
            errors++; $display("FAIL stall_after got psrc %0d pdst %0d old %0d want 46/60/46", f_psrc0(0), f_pdst(0), f_old(0)); end
        idle_inputs();
    endtask

    task automatic test_flush_commit();
        apply_reset();
        set_commit(0, 7, 30);
        step();
        idle_inputs();
        set_slot(0, 1'b1, 7, 0, 0);
        set_preg(45, 46);
        step();
        checks++; if (f_pdst(0) !== 6'd45 || f_old(0) !== 6'd7) begin
            errors++; $display("FAIL flush_pre got pdst %0d old %0d want 45/7", f_pdst(0), f_old(0)); end
        dec_valid_i = '0;
        set_slot(0, 1'b1, 9, 7, 8);
        flush_i = 1'b1;
        set_commit(1, 8, 33);
        #1;
        checks++; if (dec_ready_o !== 1'b0 || fl_alloc_valid_o !== 2'b00) begin
            errors++; $display("FAIL flush_ready got %b/%b want 0/00", dec_ready_o, fl_alloc_valid_o); end
        @(posedge clk); #1;
        checks++; if (ren_valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", ren_valid_o); end
        idle_inputs();
        set_slot(0, 1'b0, 0, 7, 8);
        step();
        checks++; if (f_psrc0(0) !== 6'd30 || f_psrc1(0) !== 6'd33) begin
            errors++; $display("FAIL flush_restore got %0d/%0d want 30/33", f_psrc0(0), f_psrc1(0)); end
        idle_inputs();
    endtask

    task automatic test_fl_not_ready();
        apply_reset();
        fl_alloc_ready_i = 1'b0;
        set_slot(0, 1'b1, 10, 1, 2);
        set_slot(1, 1'b1, 11, 10, 10);
        set_preg(20, 21);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (dec_ready_o !== 1'b0 || fl_alloc_valid_o !== 2'b00) begin
                errors++; $display("FAIL flnr_ready c%0d got %b/%b want 0/00", c, dec_ready_o, fl_alloc_valid_o); end
            @(posedge clk); #1;
            checks++; if (ren_valid_o !== 2'b00) begin errors++; $display("FAIL flnr_valid c%0d got %b want 00", c, ren_valid_o); end
        end
        fl_alloc_ready_i = 1'b1;
        #1;
        checks++; if (fl_alloc_valid_o !== 2'b11) begin errors++; $display("FAIL flnr_alloc got %b want 11", fl_alloc_valid_o); end
        @(posedge clk); #1;
        checks++; if (f_psrc0(0) !== 6'd1 || f_pdst(0) !== 6'd20 || f_old(0) !== 6'd10) begin
            errors++; $display("FAIL flnr_slot0 got %0d/%0d/%0d want 1/20/10", f_psrc0(0), f_pdst(0), f_old(0)); end
        checks++; if (f_psrc0(1) !== 6'd20 || f_pdst(1) !== 6'd21 || f_old(1) !== 6'd11) begin
            errors++; $display("FAIL flnr_slot1 got %0d/%0d/%0d want 20/21/11", f_psrc0(1), f_pdst(1), f_old(1)); end
        idle_inputs();
    endtask

    // Random traffic against a model that renames one instruction at a time
    // through a plain architectural-to-physical map.
    task automatic test_random();
        int m_spec[32], m_arch[32], tmp[32];
        int m_psrc0[2], m_psrc1[2], m_pdst[2], m_old[2];
        int e_psrc0[2], e_psrc1[2], e_pdst[2], e_old[2];
        logic [1:0] m_valid, m_wen, e_wen, exp_alloc;
        int nv, alloc, s0, s1, d;
        logic stall_m, rdy_m, fire_m;
        apply_reset();
        for (int r = 0; r < 32; r++) begin m_spec[r] = r; m_arch[r] = r; end
        m_valid = 2'b00;
        m_wen   = 2'b00;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            nv = $urandom_range(0, 2);
            for (int i = 0; i < nv; i++)
                set_slot(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            set_preg($urandom_range(0, 63), $urandom_range(0, 63));
            flush_i          = ($urandom_range(0, 11) == 0);
            fl_alloc_ready_i = ($urandom_range(0, 7) != 0);
            ren_ready_i      = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_commit(k, $urandom_range(0, 7), $urandom_range(0, 63));
                    cmt_wen_i[k] = ($urandom_range(0, 3) != 0);
                end
            end
            #1;
            stall_m = (m_valid != 2'b00) && !ren_ready_i;
            rdy_m   = fl_alloc_ready_i && !stall_m && !flush_i;
            fire_m  = (nv != 0) && rdy_m;
            tmp     = m_spec;
            alloc   = 0;
            e_wen   = 2'b00;
            for (int i = 0; i < 2; i++) begin
                e_psrc0[i] = 0; e_psrc1[i] = 0; e_pdst[i] = 0; e_old[i] = 0;
                if (i < nv) begin
                    s0 = dec_src0_i[i*AW +: AW];
                    s1 = dec_src1_i[i*AW +: AW];
                    d  = dec_dst_i[i*AW +: AW];
                    e_psrc0[i] = (s0 == 0) ? 0 : tmp[s0];
                    e_psrc1[i] = (s1 == 0) ? 0 : tmp[s1];
                    if (dec_wen_i[i] && d != 0) begin
                        e_wen[i]  = 1'b1;
                        e_old[i]  = tmp[d];
                        e_pdst[i] = fl_preg_i[alloc*PW +: PW];
                        tmp[d]    = e_pdst[i];
                        alloc++;
                    end
                end
            end
            exp_alloc = fire_m ? 2'((1 << alloc) - 1) : 2'b00;
            checks++; if (dec_ready_o !== rdy_m) begin errors++; $display("FAIL rnd_ready n%0d got %b want %b", n, dec_ready_o, rdy_m); end
            checks++; if (fl_alloc_valid_o !== exp_alloc) begin errors++; $display("FAIL rnd_alloc n%0d got %b want %b", n, fl_alloc_valid_o, exp_alloc); end
            for (int k = 0; k < 2; k++) begin
                if (cmt_valid_i[k] && cmt_wen_i[k] && cmt_dst_i[k*AW +: AW] != 0)
                    m_arch[cmt_dst_i[k*AW +: AW]] = cmt_pdst_i[k*PW +: PW];
            end
            @(posedge clk); #1;
            if (flush_i) begin
                m_spec  = m_arch;
                m_valid = 2'b00;
            end else if (fire_m) begin
                m_spec  = tmp;
                m_valid = dec_valid_i;
                m_wen   = e_wen;
                m_psrc0 = e_psrc0; m_psrc1 = e_psrc1; m_pdst = e_pdst; m_old = e_old;
            end else if (!stall_m) begin
                m_valid = 2'b00;
            end
            checks++; if (ren_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid n%0d got %b want %b", n, ren_valid_o, m_valid); end
            for (int i = 0; i < 2; i++) begin
                if (m_valid[i]) begin
                    checks++;
                    if (f_psrc0(i) !== PW'(m_psrc0[i]) || f_psrc1(i) !== PW'(m_psrc1[i]) || f_pdst(i) !== PW'(m_pdst[i])
                        || f_old(i) !== PW'(m_old[i]) || ren_wen_o[i] !== m_wen[i]) begin
                        errors++;
                        $display("FAIL rnd_slot%0d n%0d got %0d %0d %0d %0d %b want %0d %0d %0d %0d %b", i, n,
                                 f_psrc0(i), f_psrc1(i), f_pdst(i), f_old(i), ren_wen_o[i],
                                 m_psrc0[i], m_psrc1[i], m_pdst[i], m_old[i], m_wen[i]);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout reached before end of test");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_dependency();
        test_same_dst();
        test_r0_dst();
        test_stall();
        test_flush_commit();
        test_fl_not_ready();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
